unsigned_divider_16by8_seq: RTL and testbench

UNSIGNED_DIVIDER_16BY8_SEQ -- requirements
Module: unsigned_divider_16by8_seq

---
 rtl/unsigned_divider_16by8_seq.sv | 149 ++++++++++++++
 tb/tb_unsigned_divider_16by8_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/unsigned_divider_16by8_seq.sv
// Sequential 16-by-8 unsigned restoring divider: one quotient bit per cycle, MSB first,
// with valid/ready handshakes on both sides and a single-cycle divide-by-zero path.
module unsigned_divider_16by8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] z,
    input  logic [7:0]  y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic [7:0]  r,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] dvd_q, dvd_d;
    logic [7:0]  dvs_q, dvs_d;
    logic [7:0]  prem_q, prem_d;
    logic [15:0] quot_q, quot_d;
    logic [7:0]  rem_q, rem_d;
    logic        dz_q, dz_d;

    logic        in_hs;
    logic        out_hs;
    logic [8:0]  step;

    // One restoring step: returns {quotient bit, new partial remainder}.
    // The remainder after a step is always below the divisor, so 8 bits hold it.
    function automatic logic [8:0] div_step(input logic [7:0] prem,
                                            input logic       nbit,
                                            input logic [7:0] dvs);
        logic [8:0] sh;
        sh = {prem, nbit};
        if (sh >= {1'b0, dvs}) begin
            return {1'b1, sh[7:0] - dvs};
        end
        return {1'b0, sh[7:0]};
    endfunction

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;
    assign step   = div_step(prem_q, dvd_q[15], dvs_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    state_d = (y == 8'd0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 4'd0;
            dvd_q  <= 16'd0;
            dvs_q  <= 8'd0;
            prem_q <= 8'd0;
            quot_q <= 16'd0;
            rem_q  <= 8'd0;
            dz_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            prem_q <= prem_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dz_q   <= dz_d;
        end
    end

    // Dividend register doubles as the quotient shift register during BUSY.
    always_comb begin
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        prem_d = prem_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dz_d   = dz_q;
        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    cnt_d  = 4'd0;
                    dvd_d  = z;
                    dvs_d  = y;
                    prem_d = 8'd0;
                    if (y == 8'd0) begin
                        quot_d = 16'hFFFF;
                        rem_d  = z[7:0];
                        dz_d   = 1'b1;
                    end
                end
            end
            BUSY: begin
                cnt_d  = cnt_q + 4'd1;
                dvd_d  = {dvd_q[14:0], step[8]};
                prem_d = step[7:0];
                if (cnt_q == 4'd15) begin
                    quot_d = {dvd_q[14:0], step[8]};
                    rem_d  = step[7:0];
                    dz_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign q        = quot_q;
    assign r        = rem_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_unsigned_divider_16by8_seq.sv
// Scoreboard bench for the sequential 16-by-8 divider: directed corners, backpressure,
// mid-operation reset and a random regression with output stalls.
module tb_unsigned_divider_16by8_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] z;
    logic [7:0]  y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic [7:0]  r;
    logic        div_zero;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Expected results packed as {div_zero, q, r}
    logic [24:0] exp_q[$];

    unsigned_divider_16by8_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] model(input logic [15:0] zz, input logic [7:0] yy);
        int qq;
        int rr;
        if (yy == 8'd0) return {1'b1, 16'hFFFF, zz[7:0]};
        qq = int'(zz) / int'(yy);
        rr = int'(zz) % int'(yy);
        return {1'b0, qq[15:0], rr[7:0]};
    endfunction

    task automatic run_op(input logic [15:0] zz, input logic [7:0] yy,
                          input int stall, input bit hold_valid);
        int          n;
        int          hs;
        logic [24:0] e;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check_val("in_ready_wait", {31'd0, in_ready}, 32'd1);
        z        = zz;
        y        = yy;
        in_valid = 1'b1;
        exp_q.push_back(model(zz, yy));
        step();
        hs = cyc;
        if (hold_valid) begin
            z = ~zz;
            y = yy + 8'd1;
        end else begin
            in_valid = 1'b0;
            z        = 16'($urandom);
            y        = 8'($urandom);
        end
        n = 0;
        while (!out_valid && n < 40) begin
            out_ready = 1'($urandom);
            step();
            n++;
        end
        out_ready = 1'b0;
        check_val("out_valid_wait", {31'd0, out_valid}, 32'd1);
        check_val("latency", cyc - hs, (yy == 8'd0) ? 32'd0 : 32'd16);
        check_val("in_ready_done", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
            e = 25'd0;
        end else begin
            e = exp_q.pop_front();
        end
        check_val("q", {16'd0, q}, {16'd0, e[23:8]});
        check_val("r", {24'd0, r}, {24'd0, e[7:0]});
        check_val("div_zero", {31'd0, div_zero}, {31'd0, e[24]});
        if (yy != 8'd0) begin
            check_val("identity", int'(q) * int'(yy) + int'(r), {16'd0, zz});
            check_val("r_lt_y", {31'd0, (r < yy)}, 32'd1);
        end
        for (int i = 0; i < stall; i++) begin
            step();
            check_val("hold_valid", {31'd0, out_valid}, 32'd1);
            check_val("hold_q", {16'd0, q}, {16'd0, e[23:8]});
            check_val("hold_r", {24'd0, r}, {24'd0, e[7:0]});
            check_val("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        out_ready = 1'b0;
        check_val("post_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("post_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("retain_q", {16'd0, q}, {16'd0, e[23:8]});
        check_val("retain_r", {24'd0, r}, {24'd0, e[7:0]});
    endtask

    initial begin
        int          n;
        int          seen;
        logic [15:0] rz;
        logic [7:0]  ry;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        z         = 16'd0;
        y         = 8'd0;
        step();
        step();
        step();
        check_val("rst_q", {16'd0, q}, 32'd0);
        check_val("rst_r", {24'd0, r}, 32'd0);
        check_val("rst_dz", {31'd0, div_zero}, 32'd0);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        step();
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op(16'd1000, 8'd7, 0, 0);
        run_op(16'hFFFF, 8'd1, 0, 0);
        run_op(16'h00FF, 8'hFF, 0, 0);
        run_op(16'hFFFF, 8'hFF, 0, 0);
        run_op(16'h1234, 8'd0, 0, 0);
        run_op(16'hBEEF, 8'h13, 5, 1);
        run_op(16'h0000, 8'd0, 2, 1);
        run_op(16'h0000, 8'd5, 0, 0);
        run_op(16'h0005, 8'd200, 1, 0);

        // Reset in the 8th BUSY cycle, with in_valid/out_ready asserted alongside
        z        = 16'd5000;
        y        = 8'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check_val("busy_before_rst", {31'd0, in_ready}, 32'd0);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("mid_rst_q", {16'd0, q}, 32'd0);
        check_val("mid_rst_r", {24'd0, r}, 32'd0);
        check_val("mid_rst_dz", {31'd0, div_zero}, 32'd0);
        check_val("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen++;
            step();
        end
        check_val("mid_rst_no_out", seen, 32'd0);
        run_op(16'd100, 8'd10, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            n = $urandom_range(0, 9);
            case (n)
                0:       ry = 8'd0;
                1:       ry = 8'd1;
                2:       ry = 8'd255;
                default: ry = 8'($urandom);
            endcase
            n = $urandom_range(0, 7);
            case (n)
                0:       rz = 16'd0;
                1:       rz = 16'hFFFF;
                default: rz = 16'($urandom);
            endcase
            run_op(rz, ry, $urandom_range(0, 3), 1'($urandom));
        end

        check_val("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
